comparator_checker: RTL and testbench
=====================================

COMPARATOR_CHECKER -- requirements
Module: comparator_checker

Interface
REQ-001 Parameter N_VEC, default 4, number of sampled vectors per check run (legal range 1..255).
REQ-002 Parameter CNT_W, default 8, width of all counters and index outputs.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; begins a check run.
REQ-006 vld  input  1  sample strobe; a, b, g, l, e are valid this cycle.
REQ-007 a, b  input  1 each  operands driven to the 1-bit comparator under check.
REQ-008 g, l, e  input  1 each  comparator responses (greater, less, equal).
REQ-009 busy  output  1  high while a run is in progress.
REQ-010 done  output  1  high from run completion until the next start or reset.
REQ-011 pass  output  1  run verdict, meaningful only while done=1.
REQ-012 match_cnt, err_cnt  output  CNT_W each  correct and incorrect sample counts for the current or last run.
REQ-013 cov  output  4  bit {a,b} set once that operand pair has been sampled in the current run.
REQ-014 first_err_idx  output  CNT_W  sample index (0-based) of first mismatch.
REQ-015 first_err_code  output  5  captured {a,b,g,l,e} of first mismatch.

Function
REQ-016 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on the cycle the N_VEC-th accepted sample is counted; DONE->RUN on start.
REQ-017 On start (from IDLE or DONE), counters, cov, first_err_idx, first_err_code and the sample index shall clear to 0 in the same edge as entry to RUN.
REQ-018 Samples shall be accepted only when state=RUN and vld=1; vld in IDLE or DONE is ignored.
REQ-019 Expected response: g_exp=a&~b, l_exp=~a&b, e_exp=~(a^b); a sample matches only if {g,l,e} equals {g_exp,l_exp,e_exp} exactly (checks one-hot implicitly).
REQ-020 Match increments match_cnt, mismatch increments err_cnt, one cycle after the accepted sample (registered outputs).
REQ-021 first_err_idx/first_err_code shall load on the first mismatch of a run only; later mismatches shall not overwrite them.
REQ-022 Counters shall saturate at 2^CNT_W-1, never wrap.
REQ-023 busy=1 exactly while state=RUN; done=1 exactly while state=DONE.
REQ-024 pass shall be 1 in DONE iff err_cnt=0 and, when N_VEC>=4, cov=4'b1111; otherwise 0; pass shall be 0 outside DONE.
REQ-025 start asserted while in RUN shall restart the run (clear as REQ-017, remain in RUN); start and a vld on the same cycle: the restart wins and the sample is discarded.
REQ-026 The final sample and its counter update occur on the same edge that enters DONE; done rises one cycle after the N_VEC-th accepted vld.
REQ-027 Latency from start pulse to busy=1 is one cycle.

Reset
REQ-028 With rst_n=0 at a rising edge: state=IDLE, busy=0, done=0, pass=0, match_cnt=0, err_cnt=0, cov=0, first_err_idx=0, first_err_code=0.
REQ-029 Reset asserted mid-run shall abort the run with no verdict; reset has priority over start and vld.

Verification
REQ-030 Exhaustive good run: start, then vld with (a,b)=00,01,10,11 and correct g/l/e -> done=1, pass=1, match_cnt=4, err_cnt=0, cov=1111.
REQ-031 Fault injection: same sequence but sample 2 (a=1,b=0) reports g=0,l=0,e=1 -> err_cnt=1, match_cnt=3, first_err_idx=2, first_err_code=5'b10001, pass=0.
REQ-032 Coverage hole: four correct samples all a=0,b=0 -> err_cnt=0, cov=0001, pass=0.
REQ-033 Gapped vld and ignored strobes: vld pulses in IDLE, then run with vld low on alternate cycles -> only RUN samples counted, done one cycle after 4th accepted sample.
REQ-034 Restart/reset: start, two samples, start again -> counters 0, run completes after 4 new samples; separately rst_n=0 after one sample -> all outputs at REQ-028 values next cycle.
REQ-035 Multiple errors: samples 1 and 3 wrong -> err_cnt=2, first_err_idx=1 unchanged by sample 3.

Source files
------------

// File: rtl/comparator_checker.sv
// -----------------------------------------------------------------------------
// comparator_checker
//
// Self-checking monitor for a 1-bit magnitude comparator. A run is started with
// a one-cycle start pulse. During the run, every vld strobe presents one
// operand pair (a, b) together with the comparator's response (g, l, e). Each
// sample is graded against the ideal response. The run ends after N_VEC
// accepted samples, and a pass/fail verdict is then held until the next start.
//
// Parameters
//   N_VEC  number of accepted samples per run (1..255)
//   CNT_W  width of the counters and of the error-index output
//
// Ports
//   clk             rising-edge clock
//   rst_n           synchronous active-low reset (beats start and vld)
//   start           one-cycle pulse; starts a run, or restarts one in progress
//   vld             sample strobe for a, b, g, l, e
//   a, b            operands driven to the comparator under check
//   g, l, e         comparator responses: greater, less, equal
//   busy            high while a run is in progress
//   done            high from run completion until the next start or reset
//   pass            verdict; can be high only while done is high
//   match_cnt       number of correct samples in the current or last run
//   err_cnt         number of incorrect samples in the current or last run
//   cov             bit {a,b} is set once that operand pair has been sampled
//   first_err_idx   0-based sample index of the first mismatch
//   first_err_code  {a,b,g,l,e} captured at the first mismatch
// -----------------------------------------------------------------------------
module comparator_checker #(
  parameter int N_VEC = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vld,
  input  logic             a,
  input  logic             b,
  input  logic             g,
  input  logic             l,
  input  logic             e,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       cov,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [4:0]       first_err_code
);

  // The sample index only has to reach N_VEC, which never exceeds 255.
  localparam int   IDX_W    = 8;
  // Full operand coverage is demanded only when a run has room for all four
  // pairs.
  localparam logic NEED_COV = (N_VEC >= 4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] idx_sat;
  logic             accept;
  logic             resp_ok;
  logic             last_sample;

  // A restart on the same cycle as a strobe discards that sample.
  assign accept      = (state == RUN) && vld && !start;
  assign resp_ok     = ({g, l, e} == {a & ~b, ~a & b, ~(a ^ b)});
  assign last_sample = accept && (idx == IDX_W'(N_VEC - 1));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: Registers use non-blocking (<=) assignments. All flops then update
    // together from values sampled before the edge, regardless of block order.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: Every output of this block gets a default before the case. Any
    // path that leaves a variable unassigned would infer a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN: begin
        if (start)            state_nxt = RUN;
        else if (last_sample) state_nxt = DONE;
      end
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sample grading
  // ---------------------------------------------------------------------------
  // The error index saturates like the counters when CNT_W is narrower than
  // the internal index.
  always_comb begin
    idx_sat = CNT_W'(idx);
    if ((CNT_W < IDX_W) && ((idx >> CNT_W) != '0)) idx_sat = '1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      match_cnt      <= '0;
      err_cnt        <= '0;
      cov            <= '0;
      first_err_idx  <= '0;
      first_err_code <= '0;
      idx            <= '0;
    end else if (accept) begin
      idx           <= idx + 1'b1;
      cov[{a, b}]   <= 1'b1;
      if (resp_ok) begin
        if (match_cnt != '1) match_cnt <= match_cnt + 1'b1;
      end else begin
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        // err_cnt saturates and never returns to zero within a run, so a zero
        // value means this is the first mismatch.
        if (err_cnt == '0) begin
          first_err_idx  <= idx_sat;
          first_err_code <= {a, b, g, l, e};
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Status outputs, decoded from registered state and counters
  // ---------------------------------------------------------------------------
  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = (state == DONE) && (err_cnt == '0) && (!NEED_COV || (cov == 4'hF));

endmodule

// File: tb/tb_comparator_checker.sv
// -----------------------------------------------------------------------------
// tb_comparator_checker
//
// Self-checking bench for comparator_checker. The reference model keeps the
// accepted samples of the current run in a queue. All expected outputs are
// recomputed from that queue with ordinary comparisons. A second instance,
// with a long run and narrow counters, exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_comparator_checker;

  localparam int N_VEC   = 4;
  localparam int CNT_W   = 8;
  localparam int N_VEC_S = 6;
  localparam int CNT_W_S = 2;

  logic clk = 1'b0;
  logic rst_n, start, vld, a, b, g, l, e;

  logic             busy, done, pass;
  logic [CNT_W-1:0] match_cnt, err_cnt, first_err_idx;
  logic [3:0]       cov;
  logic [4:0]       first_err_code;

  logic               busy_s, done_s, pass_s;
  logic [CNT_W_S-1:0] match_cnt_s, err_cnt_s, first_err_idx_s;
  logic [3:0]         cov_s;
  logic [4:0]         first_err_code_s;

  comparator_checker #(.N_VEC(N_VEC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vld(vld),
    .a(a), .b(b), .g(g), .l(l), .e(e),
    .busy(busy), .done(done), .pass(pass),
    .match_cnt(match_cnt), .err_cnt(err_cnt), .cov(cov),
    .first_err_idx(first_err_idx), .first_err_code(first_err_code)
  );

  comparator_checker #(.N_VEC(N_VEC_S), .CNT_W(CNT_W_S)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .vld(vld),
    .a(a), .b(b), .g(g), .l(l), .e(e),
    .busy(busy_s), .done(done_s), .pass(pass_s),
    .match_cnt(match_cnt_s), .err_cnt(err_cnt_s), .cov(cov_s),
    .first_err_idx(first_err_idx_s), .first_err_code(first_err_code_s)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: run/done flags plus the accepted samples of this run.
  logic       m_run  = 1'b0;
  logic       m_done = 1'b0;
  logic [4:0] q[$];

  // Ideal comparator response for an operand pair, as {a,b,g,l,e}.
  function automatic logic [4:0] good_code(input logic ia, input logic ib);
    return {ia, ib, ia > ib, ia < ib, ia == ib};
  endfunction

  // Same operand pair with at least one response bit corrupted.
  function automatic logic [4:0] bad_code(input logic ia, input logic ib);
    logic [4:0] c;
    c = good_code(ia, ib);
    c[2:0] = c[2:0] ^ 3'($urandom_range(1, 7));
    return c;
  endfunction

  // Drive one cycle, then advance the model by the same cycle.
  task automatic cycle(input logic rs, input logic st, input logic v, input logic [4:0] code);
    rst_n = rs;
    start = st;
    vld   = v;
    {a, b, g, l, e} = code;
    @(posedge clk);
    #1;
    if (!rs) begin
      m_run = 1'b0; m_done = 1'b0; q.delete();
    end else if (st) begin
      m_run = 1'b1; m_done = 1'b0; q.delete();
    end else if (m_run && v) begin
      q.push_back(code);
      if (q.size() == N_VEC) begin
        m_run = 1'b0; m_done = 1'b1;
      end
    end
  endtask

  // Expected {busy,done,pass,match,err,cov,first_idx,first_code} from the model.
  function automatic logic [35:0] expected();
    int         mc = 0, ec = 0, fi = 0;
    logic [3:0] cv = 4'b0;
    logic [4:0] fc = 5'b0;
    logic       p;
    foreach (q[i]) begin
      logic ia, ib;
      ia = q[i][4];
      ib = q[i][3];
      cv[(ia ? 2 : 0) + (ib ? 1 : 0)] = 1'b1;
      if (q[i] == good_code(ia, ib)) mc++;
      else begin
        if (ec == 0) begin fi = i; fc = q[i]; end
        ec++;
      end
    end
    p = m_done && (ec == 0) && (cv == 4'hF);
    return {m_run, m_done, p, CNT_W'(mc), CNT_W'(ec), cv, CNT_W'(fi), fc};
  endfunction

  function automatic logic [35:0] observed();
    return {busy, done, pass, match_cnt, err_cnt, cov, first_err_idx, first_err_code};
  endfunction

  task automatic test_reset();
    // Reset must win over start and vld.
    cycle(1'b0, 1'b1, 1'b1, 5'b10100);
    checks++;
    if (observed() !== 36'h0) begin
      errors++;
      $display("FAIL reset: got %h expected %h", observed(), 36'h0);
    end
    cycle(1'b1, 1'b0, 1'b0, 5'b0);
    checks++;
    if (observed() !== expected()) begin
      errors++;
      $display("FAIL reset_idle: got %h expected %h", observed(), expected());
    end
  endtask

  task automatic test_good_run();
    cycle(1'b1, 1'b1, 1'b0, 5'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: busy got %b expected 1", busy);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b1, good_code(i[1], i[0]));
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL good_run step %0d: got %h expected %h", i, observed(), expected());
      end
    end
    checks++;
    if ({done, pass, match_cnt, err_cnt, cov} !== {1'b1, 1'b1, 8'd4, 8'd0, 4'hF}) begin
      errors++;
      $display("FAIL good_run final: got %b %b %0d %0d %b expected 1 1 4 0 1111",
               done, pass, match_cnt, err_cnt, cov);
    end
  endtask

  task automatic test_fault();
    cycle(1'b1, 1'b1, 1'b0, 5'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b1, (i == 2) ? 5'b10001 : good_code(i[1], i[0]));
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL fault step %0d: got %h expected %h", i, observed(), expected());
      end
    end
    checks++;
    if ({err_cnt, match_cnt, first_err_idx, first_err_code, pass} !== {8'd1, 8'd3, 8'd2, 5'b10001, 1'b0}) begin
      errors++;
      $display("FAIL fault final: got err=%0d match=%0d idx=%0d code=%b pass=%b expected 1 3 2 10001 0",
               err_cnt, match_cnt, first_err_idx, first_err_code, pass);
    end
  endtask

  task automatic test_cov_hole();
    cycle(1'b1, 1'b1, 1'b0, 5'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, good_code(1'b0, 1'b0));
    checks++;
    if ({done, err_cnt, cov, pass} !== {1'b1, 8'd0, 4'b0001, 1'b0}) begin
      errors++;
      $display("FAIL cov_hole: got done=%b err=%0d cov=%b pass=%b expected 1 0 0001 0",
               done, err_cnt, cov, pass);
    end
  endtask

  task automatic test_gapped();
    cycle(1'b0, 1'b0, 1'b0, 5'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, good_code(1'b1, 1'b0));
    checks++;
    if (observed() !== expected()) begin
      errors++;
      $display("FAIL gapped idle_vld: got %h expected %h", observed(), expected());
    end
    cycle(1'b1, 1'b1, 1'b0, 5'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, i[0] == 1'b0, good_code(i[2], i[1]));
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL gapped step %0d: got %h expected %h", i, observed(), expected());
      end
    end
    // Strobes in DONE are ignored as well.
    cycle(1'b1, 1'b0, 1'b1, bad_code(1'b0, 1'b1));
    checks++;
    if ({done, match_cnt, err_cnt} !== {1'b1, 8'd4, 8'd0}) begin
      errors++;
      $display("FAIL gapped done_vld: got done=%b match=%0d err=%0d expected 1 4 0", done, match_cnt, err_cnt);
    end
  endtask

  task automatic test_restart();
    cycle(1'b1, 1'b1, 1'b0, 5'b0);
    cycle(1'b1, 1'b0, 1'b1, bad_code(1'b0, 1'b0));
    cycle(1'b1, 1'b0, 1'b1, good_code(1'b1, 1'b1));
    // The restart discards the sample that arrives on the same cycle.
    cycle(1'b1, 1'b1, 1'b1, bad_code(1'b0, 1'b1));
    checks++;
    if ({busy, match_cnt, err_cnt, cov, first_err_code} !== {1'b1, 8'd0, 8'd0, 4'd0, 5'd0}) begin
      errors++;
      $display("FAIL restart clear: got busy=%b match=%0d err=%0d cov=%b code=%b expected 1 0 0 0000 00000",
               busy, match_cnt, err_cnt, cov, first_err_code);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b1, good_code(i[0], i[1]));
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL restart step %0d: got %h expected %h", i, observed(), expected());
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b1, 1'b0, 5'b0);
    cycle(1'b1, 1'b0, 1'b1, bad_code(1'b1, 1'b0));
    cycle(1'b0, 1'b0, 1'b1, good_code(1'b0, 1'b0));
    checks++;
    if (observed() !== 36'h0) begin
      errors++;
      $display("FAIL reset_mid: got %h expected %h", observed(), 36'h0);
    end
  endtask

  task automatic test_multi_err();
    logic [4:0] c1;
    c1 = bad_code(1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 5'b0);
    cycle(1'b1, 1'b0, 1'b1, good_code(1'b0, 1'b0));
    cycle(1'b1, 1'b0, 1'b1, c1);
    cycle(1'b1, 1'b0, 1'b1, good_code(1'b1, 1'b0));
    cycle(1'b1, 1'b0, 1'b1, bad_code(1'b1, 1'b1));
    checks++;
    if ({err_cnt, first_err_idx, first_err_code, pass} !== {8'd2, 8'd1, c1, 1'b0}) begin
      errors++;
      $display("FAIL multi_err: got err=%0d idx=%0d code=%b pass=%b expected 2 1 %b 0",
               err_cnt, first_err_idx, first_err_code, pass, c1);
    end
  endtask

  task automatic test_saturation();
    cycle(1'b0, 1'b0, 1'b0, 5'b0);
    cycle(1'b1, 1'b1, 1'b0, 5'b0);
    for (int i = 0; i < N_VEC_S; i++) begin
      cycle(1'b1, 1'b0, 1'b1, good_code(i[1], i[0]));
      if (i == 3) begin
        checks++;
        if ({busy_s, done_s, match_cnt_s} !== {1'b1, 1'b0, 2'd3}) begin
          errors++;
          $display("FAIL sat midrun: got busy=%b done=%b match=%0d expected 1 0 3", busy_s, done_s, match_cnt_s);
        end
      end
    end
    checks++;
    if ({done_s, pass_s, match_cnt_s, err_cnt_s} !== {1'b1, 1'b1, 2'd3, 2'd0}) begin
      errors++;
      $display("FAIL sat match: got done=%b pass=%b match=%0d err=%0d expected 1 1 3 0",
               done_s, pass_s, match_cnt_s, err_cnt_s);
    end
    cycle(1'b1, 1'b1, 1'b0, 5'b0);
    for (int i = 0; i < N_VEC_S; i++) cycle(1'b1, 1'b0, 1'b1, 5'b11100);
    checks++;
    if ({done_s, pass_s, match_cnt_s, err_cnt_s, first_err_idx_s, first_err_code_s}
        !== {1'b1, 1'b0, 2'd0, 2'd3, 2'd0, 5'b11100}) begin
      errors++;
      $display("FAIL sat err: got done=%b pass=%b match=%0d err=%0d idx=%0d code=%b expected 1 0 0 3 0 11100",
               done_s, pass_s, match_cnt_s, err_cnt_s, first_err_idx_s, first_err_code_s);
    end
  endtask

  task automatic test_random();
    cycle(1'b0, 1'b0, 1'b0, 5'b0);
    for (int i = 0; i < 600; i++) begin
      logic rs, st, v, ia, ib;
      rs = ($urandom_range(0, 39) != 0);
      st = ($urandom_range(0, 11) == 0);
      v  = 1'($urandom_range(0, 1));
      ia = 1'($urandom_range(0, 1));
      ib = 1'($urandom_range(0, 1));
      cycle(rs, st, v, ($urandom_range(0, 3) == 0) ? bad_code(ia, ib) : good_code(ia, ib));
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL random cycle %0d: got %h expected %h", i, observed(), expected());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; vld = 1'b0;
    a = 1'b0; b = 1'b0; g = 1'b0; l = 1'b0; e = 1'b0;
    test_reset();
    test_good_run();
    test_fault();
    test_cov_hole();
    test_gapped();
    test_restart();
    test_reset_mid();
    test_multi_err();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
